// File: rtl/stream_demux2.sv
// Two-way stream demultiplexer.
// Each branch buffers up to two words in its own small FIFO.
module stream_demux2_fifo #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [width-1:0] d,
  input  logic             ready,
  output logic [width-1:0] y,
  output logic             valid,
  output logic [7:0]       cnt,
  output logic [1:0]       occ
);

  logic [width-1:0] head;
  logic [width-1:0] tail;
  logic [1:0]       occ_q;
  logic             pop;

  assign valid = (occ_q != 2'd0);
  assign pop   = valid && ready;
  assign y     = valid ? head : '0;
  assign occ   = occ_q;

  // Occupancy, storage and delivered-word counter.
  // Push with pop only happens at occupancy 1: the new word replaces the head.
  always_ff @(posedge clk) begin
    if (reset) begin
      occ_q <= 2'd0;
      head  <= '0;
      tail  <= '0;
      cnt   <= 8'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occ_q == 2'd0) head <= d;
          else               tail <= d;
          occ_q <= occ_q + 2'd1;
        end
        2'b01: begin
          head  <= tail;
          occ_q <= occ_q - 2'd1;
        end
        2'b11: head <= d;
        default: ;
      endcase
      if (pop) cnt <= cnt + 8'd1;
    end
  end

endmodule

module stream_demux2 #(
  parameter int width = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [width-1:0] d,
  input  logic             s,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [width-1:0] y0,
  output logic [width-1:0] y1,
  output logic             y0_valid,
  output logic             y1_valid,
  input  logic             y0_ready,
  input  logic             y1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  logic [1:0] occ0;
  logic [1:0] occ1;
  logic       push0;
  logic       push1;

  // Selected branch must have a free slot; no pop-through when full.
  always_comb begin
    in_ready = s ? (occ1 != 2'd2) : (occ0 != 2'd2);
  end

  assign push0 = in_valid && in_ready && !s;
  assign push1 = in_valid && in_ready && s;

  stream_demux2_fifo #(.width(width)) u_b0 (
    .clk   (clk),
    .reset (reset),
    .push  (push0),
    .d     (d),
    .ready (y0_ready),
    .y     (y0),
    .valid (y0_valid),
    .cnt   (cnt0),
    .occ   (occ0)
  );

  stream_demux2_fifo #(.width(width)) u_b1 (
    .clk   (clk),
    .reset (reset),
    .push  (push1),
    .d     (d),
    .ready (y1_ready),
    .y     (y1),
    .valid (y1_valid),
    .cnt   (cnt1),
    .occ   (occ1)
  );

endmodule
